demux_registrado: RTL and testbench

// - Registered 1:N demultiplexer; the write-side counterpart of the datapath N:1 selector muxes.
// - Takes one LARGURA-bit word plus a lane select (controle), stores it in the selected lane's

---
 rtl/demux_registrado_if.sv | 25 ++
 rtl/demux_registrado.sv | 92 +++++++++
 tb/tb_demux_registrado.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/demux_registrado_if.sv
// Handshake/bus bundle between a producer, the registered 1:N demux and its NUM_SAIDAS sinks.
interface demux_registrado_if #(
    parameter int LARGURA    = 16,
    parameter int NUM_SAIDAS = 5
);
    logic [LARGURA-1:0]            entrada;
    logic [2:0]                    controle;
    logic                          valido;
    logic                          pronto;
    logic [NUM_SAIDAS*LARGURA-1:0] saidas;
    logic [NUM_SAIDAS-1:0]         saida_valida;
    logic [NUM_SAIDAS-1:0]         consumido;
    logic                          erro;
    logic [7:0]                    contagem;

    modport slave (
        input  entrada, controle, valido, consumido,
        output pronto, saidas, saida_valida, erro, contagem
    );

    modport master (
        output entrada, controle, valido, consumido,
        input  pronto, saidas, saida_valida, erro, contagem
    );
endinterface

// File: rtl/demux_registrado.sv
// Registered 1:N demux: word lands in the selected lane one cycle after accept; pronto is
// combinational from controle/lane state/consumido. Optional write counter: DEMUX_REGISTRADO_CONTADOR_EN.
module demux_registrado #(
    parameter int LARGURA    = 16,
    parameter int NUM_SAIDAS = 5
) (
    input  logic              clock,
    input  logic              reset,
    demux_registrado_if.slave bus
);
    logic [LARGURA-1:0]    dados_q [NUM_SAIDAS];
    logic [LARGURA-1:0]    dados_d [NUM_SAIDAS];
    logic [NUM_SAIDAS-1:0] valida_q, valida_d;
    logic                  erro_q, erro_d;
    logic                  sel_valido;
    logic                  pronto;
    logic                  aceita;

    // Out-of-range lanes are always ready so a bad select never deadlocks the producer.
    always_comb begin
        sel_valido = 1'b0;
        pronto     = 1'b1;
        for (int k = 0; k < NUM_SAIDAS; k++) begin
            if (bus.controle == 3'(k)) begin
                sel_valido = 1'b1;
                pronto     = ~valida_q[k] | bus.consumido[k];
            end
        end
        aceita = bus.valido & pronto;
    end

    always_comb begin
        dados_d  = dados_q;
        valida_d = valida_q;
        erro_d   = erro_q | (aceita & ~sel_valido);
        for (int k = 0; k < NUM_SAIDAS; k++) begin
            if (aceita && bus.controle == 3'(k)) begin
                dados_d[k]  = bus.entrada;
                valida_d[k] = 1'b1;
            end else if (bus.consumido[k]) begin
                valida_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < NUM_SAIDAS; k++) begin
                dados_q[k] <= '0;
            end
            valida_q <= '0;
            erro_q   <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_SAIDAS; k++) begin
                dados_q[k] <= dados_d[k];
            end
            valida_q <= valida_d;
            erro_q   <= erro_d;
        end
    end

    always_comb begin
        bus.saidas = '0;
        for (int k = 0; k < NUM_SAIDAS; k++) begin
            bus.saidas[k*LARGURA +: LARGURA] = dados_q[k];
        end
    end

    assign bus.pronto       = pronto;
    assign bus.saida_valida = valida_q;
    assign bus.erro         = erro_q;

`ifdef DEMUX_REGISTRADO_CONTADOR_EN
    logic [7:0] contagem_q, contagem_d;

    always_comb begin
        contagem_d = contagem_q + 8'(aceita & sel_valido);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            contagem_q <= 8'd0;
        end else begin
            contagem_q <= contagem_d;
        end
    end

    assign bus.contagem = contagem_q;
`else
    assign bus.contagem = 8'd0;
`endif
endmodule

// File: tb/tb_demux_registrado.sv
// Randomised and directed stimulus for demux_registrado against an array-based lane model.
module tb_demux_registrado;
    localparam int L = 16;
    localparam int N = 5;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    demux_registrado_if #(.LARGURA(L), .NUM_SAIDAS(N)) bus ();

    demux_registrado #(.LARGURA(L), .NUM_SAIDAS(N)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    logic [L-1:0] m_dado [N];
    logic [N-1:0] m_vld;
    logic         m_erro;
    int           m_cont;
    bit           modelo_ok = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic modelo_reset();
        for (int k = 0; k < N; k++) m_dado[k] = '0;
        m_vld  = '0;
        m_erro = 1'b0;
        m_cont = 0;
    endtask

    task automatic ciclo(input logic rst, input logic vld, input logic [2:0] ctl,
                         input logic [L-1:0] ent, input logic [N-1:0] cons);
        logic exp_pr;
        logic ok_ctl;
        logic [L-1:0] lane;
        @(negedge clock);
        reset          = rst;
        bus.valido     = vld;
        bus.controle   = ctl;
        bus.entrada    = ent;
        bus.consumido  = cons;
        #1;
        ok_ctl = (int'(ctl) < N);
        exp_pr = ok_ctl ? (!m_vld[ctl] || cons[ctl]) : 1'b1;
        if (modelo_ok) chk("pronto", {31'd0, bus.pronto}, {31'd0, exp_pr});
        @(posedge clock);
        if (rst) begin
            modelo_reset();
            modelo_ok = 1'b1;
        end else if (modelo_ok) begin
            for (int k = 0; k < N; k++) if (cons[k]) m_vld[k] = 1'b0;
            if (vld && exp_pr) begin
                if (ok_ctl) begin
                    m_dado[ctl] = ent;
                    m_vld[ctl]  = 1'b1;
`ifdef DEMUX_REGISTRADO_CONTADOR_EN
                    m_cont = (m_cont + 1) % 256;
`endif
                end else begin
                    m_erro = 1'b1;
                end
            end
        end
        #1;
        if (modelo_ok) begin
            for (int k = 0; k < N; k++) begin
                lane = bus.saidas[k*L +: L];
                chk($sformatf("lane%0d", k), {16'd0, lane}, {16'd0, m_dado[k]});
            end
            chk("saida_valida", {27'd0, bus.saida_valida}, {27'd0, m_vld});
            chk("erro", {31'd0, bus.erro}, {31'd0, m_erro});
            chk("contagem", {24'd0, bus.contagem}, m_cont);
        end
    endtask

    initial begin
        bus.valido    = 1'b0;
        bus.controle  = 3'd0;
        bus.entrada   = '0;
        bus.consumido = '0;

        ciclo(1'b1, 1'b0, 3'd0, 16'h0, 5'b0);
        ciclo(1'b1, 1'b0, 3'd0, 16'h0, 5'b0);
        chk("rst_saidas_lo", bus.saidas[31:0], 32'd0);
        chk("rst_saida_valida", {27'd0, bus.saida_valida}, 32'd0);
        chk("rst_erro", {31'd0, bus.erro}, 32'd0);
        chk("rst_contagem", {24'd0, bus.contagem}, 32'd0);
        chk("rst_pronto", {31'd0, bus.pronto}, 32'd1);

        ciclo(1'b0, 1'b1, 3'd2, 16'hABCD, 5'b0);
        chk("w_lane2", {16'd0, bus.saidas[47:32]}, 32'hABCD);
        chk("w_vld", {27'd0, bus.saida_valida}, 32'b00100);
        chk("w_lane0", {16'd0, bus.saidas[15:0]}, 32'd0);

        ciclo(1'b0, 1'b1, 3'd2, 16'h1111, 5'b0);
        chk("full_hold", {16'd0, bus.saidas[47:32]}, 32'hABCD);
        ciclo(1'b0, 1'b1, 3'd2, 16'h1111, 5'b00100);
        chk("cons_write", {16'd0, bus.saidas[47:32]}, 32'h1111);
        chk("cons_write_vld", {27'd0, bus.saida_valida}, 32'b00100);

        ciclo(1'b0, 1'b1, 3'd6, 16'hFFFF, 5'b0);
        chk("bad_ctl_erro", {31'd0, bus.erro}, 32'd1);
        chk("bad_ctl_lane2", {16'd0, bus.saidas[47:32]}, 32'h1111);

        ciclo(1'b1, 1'b0, 3'd0, 16'h0, 5'b0);
        for (int i = 0; i < 256; i++) begin
            ciclo(1'b0, 1'b1, 3'(i % N), 16'(i), 5'b11111);
        end
        chk("cont_wrap", {24'd0, bus.contagem}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            ciclo(1'b0, 1'b1, 3'(i), 16'h7000 + 16'(i), 5'b11111);
        end
`ifdef DEMUX_REGISTRADO_CONTADOR_EN
        chk("cont_3", {24'd0, bus.contagem}, 32'd3);
`else
        chk("cont_off", {24'd0, bus.contagem}, 32'd0);
`endif

        ciclo(1'b1, 1'b0, 3'd0, 16'h0, 5'b0);
        ciclo(1'b0, 1'b1, 3'd0, 16'hA0A0, 5'b0);
        ciclo(1'b0, 1'b1, 3'd4, 16'hB4B4, 5'b0);
        chk("pre_rst_vld", {27'd0, bus.saida_valida}, 32'b10001);
        ciclo(1'b1, 1'b1, 3'd1, 16'h5555, 5'b0);
        chk("rst_ovr_vld", {27'd0, bus.saida_valida}, 32'd0);
        chk("rst_ovr_lane1", {16'd0, bus.saidas[31:16]}, 32'd0);
        chk("rst_ovr_lane4", {16'd0, bus.saidas[79:64]}, 32'd0);

        for (int i = 0; i < 400; i++) begin
            ciclo(($urandom_range(0, 49) == 0), 1'($urandom), 3'($urandom_range(0, 7)),
                  16'($urandom), 5'($urandom));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
